// File: rtl/spi_master_multi.sv
// SPI master that shifts an address field followed by a data field to one of
// NUM_SS slaves, with run-time CPOL/CPHA, bit order and SCK divider.
module spi_master_multi #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_SS        = 4,
  parameter int DIV_WIDTH     = 16,
  localparam int SS_W         = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     rd_we,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic [SS_W-1:0]          ss_sel,
  input  logic [DIV_WIDTH-1:0]     divider,
  input  logic                     clock_phase,
  input  logic                     clock_polarity,
  input  logic                     lsb_first,
  input  logic                     MISO,
  output logic                     SCK,
  output logic                     MOSI,
  output logic [NUM_SS-1:0]        SS,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    data_read,
  output logic                     data_read_valid
);

  // Frame length in bits and SCK edge counter sizing.
  localparam int N  = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int EW = $clog2(2 * N + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N - 1);

  // state   | meaning
  // S_IDLE  | waiting for enable, SS released, SCK at CPOL
  // S_SETUP | SS asserted, SCK idle, one half-period before first edge
  // S_SHIFT | 2N SCK edges, one every divider+1 cycles
  // S_HOLD  | SS still asserted, SCK idle, one half-period
  // S_GAP   | SS released, one half-period before returning to idle
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  function automatic logic [ADDRESS_WIDTH-1:0] rev_addr(input logic [ADDRESS_WIDTH-1:0] v);
    logic [ADDRESS_WIDTH-1:0] r;
    for (int i = 0; i < ADDRESS_WIDTH; i++) r[i] = v[ADDRESS_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [EW-1:0]          edge_q, edge_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic [NUM_SS-1:0]      ss_q, ss_d;
  logic                   busy_q, busy_d;
  logic [DATA_WIDTH-1:0]  data_read_q, data_read_d;
  logic                   valid_q, valid_d;
  logic [N-1:0]           tx_q, tx_d;
  logic [DATA_WIDTH-1:0]  rx_q, rx_d;
  logic                   rd_q, rd_d;
  logic                   cpha_q, cpha_d;
  logic                   cpol_q, cpol_d;
  logic                   lsb_q, lsb_d;

  logic [ADDRESS_WIDTH-1:0] addr_field;
  logic [DATA_WIDTH-1:0]    data_field;
  logic [N-1:0]             tx_load;
  logic                     sel_in_range;

  // Build the outgoing frame so the next bit is always the MSB of the shifter.
  always_comb begin
    addr_field   = lsb_first ? rev_addr(address) : address;
    data_field   = rd_we ? '0 : (lsb_first ? rev_data(data) : data);
    tx_load      = {addr_field, data_field};
    sel_in_range = (32'(ss_sel) < 32'(NUM_SS));
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    edge_d      = edge_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ss_d        = ss_q;
    busy_d      = busy_q;
    data_read_d = data_read_q;
    valid_d     = 1'b0;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_d        = rd_q;
    cpha_d      = cpha_q;
    cpol_d      = cpol_q;
    lsb_d       = lsb_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          cnt_d   = divider;
          div_d   = divider;
          edge_d  = '0;
          rd_d    = rd_we;
          cpha_d  = clock_phase;
          cpol_d  = clock_polarity;
          lsb_d   = lsb_first;
          sck_d   = clock_polarity;
          rx_d    = '0;
          ss_d    = '1;
          if (sel_in_range) ss_d[ss_sel] = 1'b0;
          // CPHA=0 presents the first bit before the first edge; CPHA=1 waits for it.
          if (clock_phase) begin
            mosi_d = 1'b0;
            tx_d   = tx_load;
          end else begin
            mosi_d = tx_load[N-1];
            tx_d   = tx_load << 1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d  = div_q;
          sck_d  = ~sck_q;
          edge_d = edge_q + EW'(1);
          // Leading edge is the one leaving CPOL; sample on leading when CPHA=0.
          if ((sck_q == cpol_q) != cpha_q) begin
            rx_d = (rx_q << 1) | DATA_WIDTH'(MISO);
          end else begin
            mosi_d = tx_q[N-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == LAST_EDGE) begin
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          ss_d    = '1;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (rd_q) begin
            data_read_d = lsb_q ? rev_data(rx_q) : rx_q;
            valid_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ss_d    = '1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer without a result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      edge_q      <= '0;
      sck_q       <= clock_polarity;
      mosi_q      <= 1'b0;
      ss_q        <= '1;
      busy_q      <= 1'b0;
      data_read_q <= '0;
      valid_q     <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_q        <= 1'b0;
      cpha_q      <= 1'b0;
      cpol_q      <= clock_polarity;
      lsb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      edge_q      <= edge_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      busy_q      <= busy_d;
      data_read_q <= data_read_d;
      valid_q     <= valid_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_q        <= rd_d;
      cpha_q      <= cpha_d;
      cpol_q      <= cpol_d;
      lsb_q       <= lsb_d;
    end
  end

  assign SCK             = sck_q;
  assign MOSI            = mosi_q;
  assign SS              = ss_q;
  assign busy            = busy_q;
  assign data_read       = data_read_q;
  assign data_read_valid = valid_q;

endmodule
